// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for the digit-serial add/sub unit.
// master = operand source + result consumer, slave = the arithmetic block.
interface addsub_serial_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: W-bit operation, D bits per cycle, LSB first.
// Subtraction is A + ~B + 1; B is inverted at accept and the +1 rides in as
// the initial carry. Handshake readiness is decoded from the state register only.
module addsub_serial #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_serial_if.slave     bus,
  output logic               busy
);
  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  op_a, op_b, sum_r, sum_nxt;
  logic          c;
  logic [CW-1:0] cnt;
  logic          last;
  logic [D-1:0]  sa, sb;
  logic [D:0]    tot;
  logic          cin_msb;
  logic          carry_r, overflow_r, zero_r, negative_r;

  assign last = (cnt == CW'(N - 1));

  // Current slice add; also rebuilds the full sum with this slice merged in so
  // zero/negative can be taken from the final value on the last slice.
  always_comb begin
    sa      = op_a[int'(cnt) * D +: D];
    sb      = op_b[int'(cnt) * D +: D];
    tot     = {1'b0, sa} + {1'b0, sb} + {{D{1'b0}}, c};
    // carry into the top bit of the slice, recovered from its sum bit
    cin_msb = tot[D-1] ^ sa[D-1] ^ sb[D-1];
    sum_nxt = sum_r;
    sum_nxt[int'(cnt) * D +: D] = tot[D-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, N slices in BUSY, hold in DONE until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = BUSY;
      BUSY:    if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice iteration and final flag registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      c          <= 1'b0;
      cnt        <= '0;
      sum_r      <= '0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      negative_r <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        op_a <= bus.a;
        op_b <= bus.b ^ {W{bus.sub}};
        c    <= bus.sub;
        cnt  <= '0;
      end
    end else if (state == BUSY) begin
      sum_r <= sum_nxt;
      c     <= tot[D];
      cnt   <= cnt + CW'(1);
      if (last) begin
        carry_r    <= tot[D];
        overflow_r <= cin_msb ^ tot[D];
        zero_r     <= (sum_nxt == '0);
        negative_r <= sum_nxt[W-1];
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == BUSY);
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.negative  = negative_r;
endmodule
